// File: rtl/sum_carry_packer.sv
// Packs serial (sum, carry) bit pairs into WIDTH-bit words with popcount, carry parity and length.
// Word valid 1 cycle after its last beat; in_ready drops only when the final bit of a word (or a pending flush) has no free output slot.
module sum_carry_packer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a_in,
    input  logic             cout_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [WIDTH-1:0] out_carry,
    output logic [CNT_W-1:0] out_len,
    output logic [CNT_W-1:0] out_ones,
    output logic             out_parity
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FILL,
        S_FLUSH_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

    logic [CNT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0] r_sum_sh;
    logic [WIDTH-1:0] r_carry_sh;
    logic             r_flush_pend;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_sum;
    logic [WIDTH-1:0] r_out_carry;
    logic [CNT_W-1:0] r_out_len;
    logic [CNT_W-1:0] r_out_ones;
    logic             r_out_parity;

    state_t           w_state;
    logic             w_slot_free;
    logic             w_beat;
    logic [CNT_W-1:0] w_cnt_eff;
    logic [WIDTH-1:0] w_sum_nxt;
    logic [WIDTH-1:0] w_carry_nxt;
    logic [CNT_W-1:0] w_ones;
    logic             w_full;
    logic             w_flush_now;
    logic             w_pend_emit;
    logic             w_pend_set;
    logic             w_load;

    always_comb begin
        w_state = S_EMPTY;
        if (r_flush_pend) begin
            w_state = S_FLUSH_WAIT;
        end else if (r_bit_cnt != '0) begin
            w_state = S_FILL;
        end
    end

    assign w_slot_free = !r_out_valid || out_ready;

    always_comb begin
        in_ready = 1'b1;
        if (w_state == S_FLUSH_WAIT) begin
            in_ready = 1'b0;
        end else if (w_state == S_FILL && r_bit_cnt == LAST_IDX && !w_slot_free) begin
            in_ready = 1'b0;
        end
    end

    assign w_beat    = in_valid && in_ready;
    assign w_cnt_eff = r_bit_cnt + {{(CNT_W-1){1'b0}}, w_beat};

    // Word as it would look after this edge's beat, so flush and full loads see the same data.
    always_comb begin
        w_sum_nxt   = r_sum_sh;
        w_carry_nxt = r_carry_sh;
        w_ones      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_beat && r_bit_cnt == CNT_W'(i)) begin
                w_sum_nxt[i]   = a_in;
                w_carry_nxt[i] = cout_in;
            end
        end
        for (int i = 0; i < WIDTH; i++) begin
            w_ones = w_ones + {{(CNT_W-1){1'b0}}, w_sum_nxt[i]};
        end
    end

    assign w_full      = w_beat && (w_cnt_eff == FULL_CNT);
    assign w_flush_now = !r_flush_pend && flush && !w_full && (w_cnt_eff != '0) && w_slot_free;
    assign w_pend_set  = !r_flush_pend && flush && !w_full && (w_cnt_eff != '0) && !w_slot_free;
    assign w_pend_emit = r_flush_pend && w_slot_free;
    assign w_load      = w_full || w_flush_now || w_pend_emit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt    <= '0;
            r_sum_sh     <= '0;
            r_carry_sh   <= '0;
            r_flush_pend <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_sum    <= '0;
            r_out_carry  <= '0;
            r_out_len    <= '0;
            r_out_ones   <= '0;
            r_out_parity <= 1'b0;
        end else begin
            if (w_load) begin
                // Clearing the shift registers keeps bits above out_len zero in later partial words.
                r_bit_cnt    <= '0;
                r_sum_sh     <= '0;
                r_carry_sh   <= '0;
                r_flush_pend <= 1'b0;
                r_out_valid  <= 1'b1;
                r_out_sum    <= w_sum_nxt;
                r_out_carry  <= w_carry_nxt;
                r_out_len    <= w_cnt_eff;
                r_out_ones   <= w_ones;
                r_out_parity <= ^w_carry_nxt;
            end else begin
                r_bit_cnt  <= w_cnt_eff;
                r_sum_sh   <= w_sum_nxt;
                r_carry_sh <= w_carry_nxt;
                if (w_pend_set) begin
                    r_flush_pend <= 1'b1;
                end
                if (out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_sum    = r_out_sum;
    assign out_carry  = r_out_carry;
    assign out_len    = r_out_len;
    assign out_ones   = r_out_ones;
    assign out_parity = r_out_parity;

endmodule
